branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencing controller for the shared branch comparator in the EX stage of the RV32I core. It accepts one control-transfer instruction per handshake and drives the comparator's signedness select. It decodes `funct3` against the comparator flags to resolve taken/not-taken and computes the target. On a mispredict it issues a registered redirect and holds a pipeline flush for a fixed number of cycles, stalling new requests meanwhile.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush_o` stays high after a mispredict. Legal range is ≥1.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `req_valid_i` in 1: EX holds a branch/jump this cycle.
- `req_ready_o` out 1: controller can accept a request.
- `funct3_i` in 3: branch condition code.
- `is_jal_i` in 1: JAL instruction.
- `is_jalr_i` in 1: JALR instruction.
- `pc_i` in 32: instruction PC.
- `rs1_data_i` in 32: rs1 value, used for the JALR base.
- `imm_i` in 32: sign-extended immediate.
- `pred_taken_i` in 1: fetch-stage prediction.
- `br_unsigned_o` out 1: signedness select driven to the comparator.
- `br_less_i` in 1: comparator flag.
- `br_equal_i` in 1: comparator flag.
- `br_greater_i` in 1: comparator flag.
- `res_valid_o` out 1: result pulse.
- `res_taken_o` out 1: resolved direction.
- `res_target_o` out 32: computed target.
- `illegal_o` out 1: `funct3` was 010 or 011 on a conditional branch.
- `redirect_valid_o` out 1: fetch redirect pulse.
- `redirect_pc_o` out 32: correct next PC.
- `flush_o` out 1: squash IF/ID.
- `br_count_o` out CNT_W: resolved requests.
- `mispred_count_o` out CNT_W: mispredicts.

## Operation
- FSM states are IDLE and FLUSH.
  - `req_ready_o` = 1 only in IDLE.
  - A request is accepted when `req_valid_i && req_ready_o`.
- `br_unsigned_o` is combinational and equals `funct3_i[1]` (BLTU/BGEU). The comparator is combinational, so its flags are sampled in the same cycle as the accept.
- Taken decode for conditional branches:
  - 000: `br_equal_i`
  - 001: `!br_equal_i`
  - 100 and 110: `br_less_i`
  - 101 and 111: `!br_less_i`
  - 010 and 011: not taken, with `illegal_o` = 1.
- JAL and JALR are always taken. If both `is_jal_i` and `is_jalr_i` are set, JALR wins.
- Targets, computed modulo 2^32:
  - branch/JAL: `pc_i + imm_i`
  - JALR: `(rs1_data_i + imm_i) & ~32'h1`
  - The next PC is the target if taken, else `pc_i + 4`.
- A request is a mispredict when taken ≠ `pred_taken_i`. JALR is always a mispredict because there is no target prediction.
- On a mispredict:
  - `redirect_valid_o` pulses and `redirect_pc_o` = the next PC.
  - The FSM goes to FLUSH, with `flush_o` high for FLUSH_CYCLES cycles, then returns to IDLE.
- Without a mispredict the FSM stays in IDLE, so back-to-back requests are accepted every cycle.
- Counters saturate at all-ones and never wrap.

## Timing
- An accept at edge k produces, for one cycle in k+1:
  - `res_valid_o`, `res_taken_o`, `res_target_o`, `illegal_o`
  - `redirect_valid_o` and `redirect_pc_o` when mispredicted.
- After a mispredict, `flush_o` is high for cycles k+1 through k+FLUSH_CYCLES.
  - `req_ready_o` is low for the same cycles and returns high in cycle k+FLUSH_CYCLES+1.
- A `req_valid_i` presented while in FLUSH is ignored and not latched. The requester holds it until ready.
- Counters update at the accept edge, so their new values are visible in k+1.
- Reset (`rst_ni` = 0 at an edge) takes priority over everything, including an active FLUSH. The FSM returns to IDLE with no residual flush.
- Reset values:
  - 0: `res_*`, `illegal_o`, `redirect_valid_o`, `redirect_pc_o`, `flush_o`, both counters.
  - 1: `req_ready_o` (the FSM is in IDLE).

## Configuration
- `BRANCH_STATS_EN`:
  - Defined: `br_count_o` and `mispred_count_o` count as specified above.
  - Undefined: the counter registers are not built, and both ports are tied to 0. The port list is unchanged.

## Test plan
- BEQ, pc=0x100, imm=0x20, `br_equal_i`=1, pred=1 → k+1: taken=1, target=0x120, no redirect, `flush_o`=0, ready stays 1.
- BLTU, `br_less_i`=1, pred=0, pc=0x200, imm=0x40 → `br_unsigned_o`=1 during accept. k+1: `redirect_pc_o`=0x240. `flush_o` is high for exactly 2 cycles, and ready returns in k+3.
- BGE, `br_less_i`=1, pred=1, pc=0x300 → not taken, mispredict, `redirect_pc_o`=0x304.
- JALR, rs1=0x1001, imm=0x6 → target=0x1006 and a redirect even when pred=1.
- funct3=010 → `illegal_o`=1 and taken=0. Separately: assert reset during the FLUSH cycles → the next cycle shows `flush_o`=0, ready=1, and counters at 0.
- With `BRANCH_STATS_EN` defined and CNT_W=2, send 5 requests including 4 mispredicts → both counters saturate at 3.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - EX-stage branch resolve, redirect and flush sequencer (optional stats: BRANCH_STATS_EN)
module branch_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      imm_i,
  input  logic             pred_taken_i,
  output logic             br_unsigned_o,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  input  logic             br_greater_i,
  output logic             res_valid_o,
  output logic             res_taken_o,
  output logic [31:0]      res_target_o,
  output logic             illegal_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic [31:0]       res_target_q, res_target_d;
  logic              illegal_q, illegal_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;

  logic              accept;
  logic              taken_c;
  logic              illegal_c;
  logic              mispred_c;
  logic [31:0]       target_c;
  logic [31:0]       next_pc_c;

  // Only less/equal are needed to resolve every RV32I condition.
  logic unused_flags;
  assign unused_flags = br_greater_i;

  assign br_unsigned_o = funct3_i[1];
  assign req_ready_o   = (state_q == IDLE);
  assign accept        = req_valid_i && req_ready_o;

  // Resolve direction and target of the instruction currently in EX.
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    target_c  = pc_i + imm_i;
    if (is_jalr_i) begin
      taken_c  = 1'b1;
      target_c = (rs1_data_i + imm_i) & ~32'h1;
    end else if (is_jal_i) begin
      taken_c = 1'b1;
    end else begin
      case (funct3_i)
        3'b000:         taken_c = br_equal_i;
        3'b001:         taken_c = !br_equal_i;
        3'b100, 3'b110: taken_c = br_less_i;
        3'b101, 3'b111: taken_c = !br_less_i;
        default:        illegal_c = 1'b1;
      endcase
    end
    next_pc_c = taken_c ? target_c : (pc_i + 32'd4);
    mispred_c = is_jalr_i || (taken_c != pred_taken_i);
  end

  // Next-state for the IDLE/FLUSH sequencer and the registered result/redirect outputs.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    res_valid_d      = accept;
    res_taken_d      = res_taken_q;
    res_target_d     = res_target_q;
    illegal_d        = illegal_q;
    redirect_valid_d = accept && mispred_c;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          res_taken_d  = taken_c;
          res_target_d = target_c;
          illegal_d    = illegal_c;
          if (mispred_c) begin
            redirect_pc_d = next_pc_c;
            state_d       = FLUSH;
            flush_cnt_d   = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = IDLE;
        else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides an in-progress flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_target_q     <= '0;
      illegal_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_target_q     <= res_target_d;
      illegal_q        <= illegal_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush_o          = (state_q == FLUSH);
  assign res_valid_o      = res_valid_q;
  assign res_taken_o      = res_taken_q;
  assign res_target_o     = res_target_q;
  assign illegal_o        = illegal_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Saturating counts of resolved requests and mispredicts.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (accept && (br_cnt_q != '1))              br_cnt_d  = br_cnt_q + CNT_W'(1);
    if (accept && mispred_c && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mis_cnt_q;
`else
  assign br_count_o      = '0;
  assign mispred_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - vector, sequence and randomized checks for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  localparam int FC = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready_o;
  logic [2:0] funct3 = '0;
  logic is_jal = 1'b0, is_jalr = 1'b0;
  logic [31:0] pc = '0, rs1 = '0, imm = '0;
  logic pred = 1'b0;
  logic br_unsigned_o;
  logic br_less = 1'b0, br_equal = 1'b0, br_greater = 1'b0;
  logic res_valid_o, res_taken_o, illegal_o, redirect_valid_o, flush_o;
  logic [31:0] res_target_o, redirect_pc_o;
  logic [CW-1:0] br_count_o, mispred_count_o;

  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .funct3_i(funct3), .is_jal_i(is_jal), .is_jalr_i(is_jalr), .pc_i(pc),
    .rs1_data_i(rs1), .imm_i(imm), .pred_taken_i(pred), .br_unsigned_o(br_unsigned_o),
    .br_less_i(br_less), .br_equal_i(br_equal), .br_greater_i(br_greater),
    .res_valid_o(res_valid_o), .res_taken_o(res_taken_o), .res_target_o(res_target_o),
    .illegal_o(illegal_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .flush_o(flush_o), .br_count_o(br_count_o), .mispred_count_o(mispred_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        jal, jalr;
    logic [31:0] pc, rs1, imm;
    logic        pred, less, eq, gt;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_ill, exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_br = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    if (n >= (1 << CW) - 1) return (1 << CW) - 1;
    return n;
  endfunction

  task automatic chk_counts();
`ifdef BRANCH_STATS_EN
    chk("br_count", {28'b0, br_count_o}, sat(n_br));
    chk("mispred_count", {28'b0, mispred_count_o}, sat(n_mis));
`else
    chk("br_count_tied", {28'b0, br_count_o}, 32'h0);
    chk("mispred_count_tied", {28'b0, mispred_count_o}, 32'h0);
`endif
  endtask

  // Hand-computed vector: flags given directly.
  function automatic vec_t tv(input logic [2:0] f3, input logic jal, input logic jalr,
                              input logic [31:0] p, input logic [31:0] r, input logic [31:0] i,
                              input logic pr, input logic ls, input logic e,
                              input logic et, input logic [31:0] etg, input logic eil,
                              input logic erd, input logic [31:0] erpc);
    vec_t v;
    v.f3 = f3; v.jal = jal; v.jalr = jalr; v.pc = p; v.rs1 = r; v.imm = i;
    v.pred = pr; v.less = ls; v.eq = e; v.gt = !ls && !e;
    v.exp_taken = et; v.exp_target = etg; v.exp_ill = eil; v.exp_redir = erd; v.exp_rpc = erpc;
    return v;
  endfunction

  // Reference model: branch semantics evaluated on the actual operands a, b.
  function automatic vec_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                 input logic [31:0] p, input logic [31:0] r, input logic [31:0] i,
                                 input logic pr, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    logic [31:0] t;
    v.f3 = f3; v.jal = jal; v.jalr = jalr; v.pc = p; v.rs1 = r; v.imm = i; v.pred = pr;
    v.eq   = (a == b);
    v.less = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    v.gt   = f3[1] ? (a > b) : ($signed(a) > $signed(b));
    v.exp_ill = 1'b0;
    if (jalr) begin
      t = r + i;
      t[0] = 1'b0;
      v.exp_taken = 1'b1;
      v.exp_target = t;
    end else begin
      v.exp_target = p + i;
      if (jal) v.exp_taken = 1'b1;
      else begin
        case (f3)
          3'd0: v.exp_taken = (a == b);
          3'd1: v.exp_taken = (a != b);
          3'd4: v.exp_taken = $signed(a) < $signed(b);
          3'd5: v.exp_taken = $signed(a) >= $signed(b);
          3'd6: v.exp_taken = a < b;
          3'd7: v.exp_taken = a >= b;
          default: begin v.exp_taken = 1'b0; v.exp_ill = 1'b1; end
        endcase
      end
    end
    v.exp_redir = jalr || (v.exp_taken != pr);
    v.exp_rpc = v.exp_taken ? v.exp_target : p + 32'd4;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    funct3 = v.f3; is_jal = v.jal; is_jalr = v.jalr; pc = v.pc; rs1 = v.rs1; imm = v.imm;
    pred = v.pred; br_less = v.less; br_equal = v.eq; br_greater = v.gt;
    req_valid = 1'b1;
  endtask

  task automatic chk_result(input vec_t v);
    chk("res_valid", res_valid_o, 1'b1);
    chk("res_taken", res_taken_o, v.exp_taken);
    chk("res_target", res_target_o, v.exp_target);
    chk("illegal", illegal_o, v.exp_ill);
    chk("redirect_valid", redirect_valid_o, v.exp_redir);
    if (v.exp_redir) chk("redirect_pc", redirect_pc_o, v.exp_rpc);
  endtask

  // Full request: accept, result, and (on mispredict) the flush window.
  task automatic run_req(input vec_t v);
    drive(v);
    #1;
    chk("ready_before", req_ready_o, 1'b1);
    chk("br_unsigned", br_unsigned_o, v.f3[1]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_br++;
    if (v.exp_redir) n_mis++;
    chk_result(v);
    chk("flush_k1", flush_o, v.exp_redir);
    chk("ready_k1", req_ready_o, !v.exp_redir);
    chk_counts();
    if (v.exp_redir) begin
      for (int i = 1; i < FC; i++) begin
        @(posedge clk); #1;
        chk("flush_hold", flush_o, 1'b1);
        chk("ready_low", req_ready_o, 1'b0);
      end
      @(posedge clk); #1;
      chk("flush_end", flush_o, 1'b0);
      chk("ready_back", req_ready_o, 1'b1);
      chk("res_valid_idle", res_valid_o, 1'b0);
    end
  endtask

  vec_t tbl[12];
  vec_t v;
  logic [31:0] a, b;
  int kind;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = tv(3'd0, 0, 0, 32'h100, 0, 32'h20, 1, 0, 1, 1, 32'h120, 0, 0, 0);
    tbl[1]  = tv(3'd6, 0, 0, 32'h200, 0, 32'h40, 0, 1, 0, 1, 32'h240, 0, 1, 32'h240);
    tbl[2]  = tv(3'd5, 0, 0, 32'h300, 0, 32'h10, 1, 1, 0, 0, 32'h310, 0, 1, 32'h304);
    tbl[3]  = tv(3'd0, 0, 1, 32'h0, 32'h1001, 32'h6, 1, 0, 0, 1, 32'h1006, 0, 1, 32'h1006);
    tbl[4]  = tv(3'd2, 0, 0, 32'h400, 0, 32'h8, 0, 0, 0, 0, 32'h408, 1, 0, 0);
    tbl[5]  = tv(3'd0, 1, 0, 32'h500, 0, 32'hFFFFFFF0, 1, 0, 0, 1, 32'h4F0, 0, 0, 0);
    tbl[6]  = tv(3'd0, 1, 0, 32'h500, 0, 32'hFFFFFFF0, 0, 0, 0, 1, 32'h4F0, 0, 1, 32'h4F0);
    tbl[7]  = tv(3'd0, 1, 1, 32'h600, 32'h2000, 32'h11, 1, 0, 0, 1, 32'h2010, 0, 1, 32'h2010);
    tbl[8]  = tv(3'd1, 0, 0, 32'hFFFFFFFC, 0, 32'h8, 0, 0, 0, 1, 32'h4, 0, 1, 32'h4);
    tbl[9]  = tv(3'd7, 0, 0, 32'h700, 0, 32'hFFFFFFFC, 1, 0, 0, 1, 32'h6FC, 0, 0, 0);
    tbl[10] = tv(3'd3, 0, 0, 32'h800, 0, 32'h0, 1, 0, 0, 0, 32'h800, 1, 1, 32'h804);
    tbl[11] = tv(3'd4, 0, 0, 32'h900, 0, 32'h100, 0, 1, 0, 1, 32'hA00, 0, 1, 32'hA00);

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_res_taken", res_taken_o, 1'b0);
    chk("rst_res_target", res_target_o, 32'h0);
    chk("rst_illegal", illegal_o, 1'b0);
    chk("rst_redirect_valid", redirect_valid_o, 1'b0);
    chk("rst_redirect_pc", redirect_pc_o, 32'h0);
    chk_counts();
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_req(tbl[i]);

    // Request held during FLUSH is ignored, then accepted once ready returns.
    drive(tbl[2]);
    @(posedge clk); #1;
    n_br++; n_mis++;
    chk_result(tbl[2]);
    drive(tbl[0]);
    chk("seq_flush_k1", flush_o, 1'b1);
    @(posedge clk); #1;
    chk("seq_flush_k2", flush_o, 1'b1);
    chk("seq_ignored", res_valid_o, 1'b0);
    chk_counts();
    @(posedge clk); #1;
    chk("seq_ready_k3", req_ready_o, 1'b1);
    chk("seq_flush_k3", flush_o, 1'b0);
    chk("seq_still_ignored", res_valid_o, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_br++;
    chk_result(tbl[0]);
    chk_counts();

    // Reset asserted in the middle of a flush.
    drive(tbl[1]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rf_flush_before", flush_o, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    n_br = 0; n_mis = 0;
    chk("rf_flush", flush_o, 1'b0);
    chk("rf_ready", req_ready_o, 1'b1);
    chk("rf_res_valid", res_valid_o, 1'b0);
    chk("rf_redirect_valid", redirect_valid_o, 1'b0);
    chk_counts();

    // Randomized requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      v = model(3'($urandom_range(0, 7)), kind == 8 || (kind == 9 && $urandom_range(0, 1) == 1),
                kind == 9, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), a, b);
      if (kind < 8) begin
        v = model(3'(kind), 1'b0, 1'b0, v.pc, v.rs1, v.imm, v.pred, a, b);
      end
      run_req(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
